logic_gate_checker: RTL and testbench

//   Sequential exerciser/checker for the seven basic 2-input gates (AND, OR, NOT, NAND, NOR, XOR, XNOR).
//   It drives the A/B inputs through all four combinations and reads back the seven Y outputs.
//   It compares them with golden values and reports pass/fail per gate.

---
 rtl/logic_gate_checker_pkg.sv | 34 +++
 rtl/gate_golden_model.sv | 30 +++
 rtl/logic_gate_checker.sv | 155 +++++++++++++++
 tb/tb_logic_gate_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_checker_pkg.sv
// rtl/logic_gate_checker_pkg.sv - shared gate indices, FSM encoding and popcount helper
//
// Purpose: common definitions for the gate exerciser/checker and its golden model.
// Ports: none (package).
package logic_gate_checker_pkg;

    localparam int NUM_GATES = 7;

    // Bit positions inside Y_vec / fail_mask
    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOT  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_NOR  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - combinational expected outputs of the seven 2-input gates
//
// Purpose: for a stimulus vector {A,B} = vec, produce the value every gate must output.
// Ports:
//   vec  in  2  {A,B} stimulus (A = vec[1], B = vec[0])
//   exp  out 7  expected Y_vec, bit order AND,OR,NOT,NAND,NOR,XOR,XNOR
module gate_golden_model
    import logic_gate_checker_pkg::*;
(
    input  logic [1:0]           vec,
    output logic [NUM_GATES-1:0] exp
);

    logic a;
    logic b;

    always_comb begin
        a              = vec[1];
        b              = vec[0];
        exp            = '0;
        exp[GATE_AND]  = a & b;
        exp[GATE_OR]   = a | b;
        exp[GATE_NOT]  = ~a;
        exp[GATE_NAND] = ~(a & b);
        exp[GATE_NOR]  = ~(a | b);
        exp[GATE_XOR]  = a ^ b;
        exp[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/logic_gate_checker.sv
// rtl/logic_gate_checker.sv - sequential exerciser/checker for the seven basic gates
//
// Purpose: on start, walk {A,B} through 00,01,10,11, hold each vector SETTLE_CYCLES
// cycles, sample Y_vec once per vector and accumulate per-gate mismatch flags and a
// saturating mismatch count.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (only honoured in IDLE)
//   A, B            stimulus to the gate library
//   Y_vec[6:0]      gate outputs, bit order AND,OR,NOT,NAND,NOR,XOR,XNOR
//   busy            run in progress
//   done            one-cycle end-of-run pulse
//   pass            no mismatches in the last run (held until next start)
//   fail_mask[6:0]  sticky per-gate mismatch flags
//   err_count[4:0]  total mismatched bits, saturating at 31
module logic_gate_checker
    import logic_gate_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 A,
    output logic                 B,
    input  logic [NUM_GATES-1:0] Y_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [4:0]           err_count
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e               state_q, state_d;
    logic [1:0]           vec_q, vec_d;
    logic [3:0]           settle_q, settle_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
    logic [4:0]           err_count_q, err_count_d;

    logic [NUM_GATES-1:0] exp_y;
    logic [NUM_GATES-1:0] mism;
    logic [5:0]           err_sum;

    gate_golden_model u_golden (
        .vec (vec_q),
        .exp (exp_y)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        mism        = '0;
        err_sum     = '0;

        case (state_q)
            ST_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    vec_d       = 2'b00;
                    settle_d    = '0;
                    fail_mask_d = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                mism        = Y_vec ^ exp_y;
                fail_mask_d = fail_mask_q | mism;
                err_sum     = {1'b0, err_count_q} + {3'b000, popcount7(mism)};
                err_count_d = (err_sum > 6'd31) ? 5'd31 : err_sum[4:0];
                if (vec_q == 2'b11) begin
                    state_d = ST_DONE;
                end else begin
                    // A/B move together with vec so the next DRIVE window starts on the new vector
                    vec_d   = vec_q + 2'd1;
                    a_d     = vec_d[1];
                    b_d     = vec_d[0];
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (fail_mask_q == '0);
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            settle_q    <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_logic_gate_checker.sv
// tb/tb_logic_gate_checker.sv - self-checking bench for logic_gate_checker
module tb_logic_gate_checker;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start_s, a_s, b_s, busy_s, done_s, pass_s;
    logic [1:0][6:0] y_s, fm_s;
    logic [1:0][4:0] ec_s;
    logic [6:0] flip_tab [4];
    logic [6:0] stuck0;
    logic [6:0] glitch;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_gate_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .A(a_s[0]), .B(b_s[0]), .Y_vec(y_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .fail_mask(fm_s[0]), .err_count(ec_s[0])
    );

    logic_gate_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_s[1]), .A(a_s[1]), .B(b_s[1]), .Y_vec(y_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .fail_mask(fm_s[1]), .err_count(ec_s[1])
    );

    // Truth of each gate expressed arithmetically on 0/1 operands
    function automatic logic [6:0] ref_gates(input int a, input int b);
        logic [6:0] r;
        r[0] = (a * b == 1);
        r[1] = (a + b >= 1);
        r[2] = (a == 0);
        r[3] = (a * b == 0);
        r[4] = (a + b == 0);
        r[5] = (a + b == 1);
        r[6] = (a == b);
        return r;
    endfunction

    // Gate library under test, with injectable faults and settle-window glitches
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            y_s[i] = ((ref_gates(int'(a_s[i]), int'(b_s[i])) ^ flip_tab[{a_s[i], b_s[i]}]) & ~stuck0) ^ glitch;
        end
    end

    function automatic int popc(input logic [6:0] m);
        int c = 0;
        for (int g = 0; g < 7; g++) c += (int'(m) >> g) & 1;
        return c;
    endfunction

    task automatic set_faults(input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2,
                              input logic [6:0] f3, input logic [6:0] st0);
        flip_tab[0] = f0; flip_tab[1] = f1; flip_tab[2] = f2; flip_tab[3] = f3;
        stuck0 = st0;
    endtask

    // One run on DUT d (settle s). Start sampled at edge 0; cycle k is the cycle after edge k.
    task automatic run(input int d, input int s, input bit glitchy, input int repulse_k, input int rst_k,
                       input logic [6:0] e_fm, input logic [4:0] e_ec, input bit e_pass, input string name);
        int lat = 4 * (s + 1) + 1;
        @(posedge clk); #1;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        for (int k = 0; k <= lat + 2; k++) begin
            automatic int j = k / (s + 1);
            if (rst_k >= 0 && k > rst_k) begin
                if (k == rst_k + 1) begin
                    n_checks++;
                    if (busy_s[d] !== 1'b0 || a_s[d] !== 1'b0 || b_s[d] !== 1'b0 || fm_s[d] !== 7'h00 || ec_s[d] !== 5'd0) begin
                        n_fail++;
                        $display("FAIL %s rst_outputs k=%0d: busy=%b A=%b B=%b fm=%h ec=%0d, required all 0", name, k, busy_s[d], a_s[d], b_s[d], fm_s[d], ec_s[d]);
                    end
                end
                n_checks++;
                if (done_s[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s done_after_rst k=%0d: done=%b, required 0", name, k, done_s[d]);
                end
            end else begin
                if (k < lat - 1) begin
                    n_checks++;
                    if (a_s[d] !== j[1] || b_s[d] !== j[0]) begin
                        n_fail++;
                        $display("FAIL %s stim k=%0d: A=%b B=%b, required A=%b B=%b", name, k, a_s[d], b_s[d], j[1], j[0]);
                    end
                end
                if (k < lat) begin
                    n_checks++;
                    if (busy_s[d] !== 1'b1 || done_s[d] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s busy_phase k=%0d: busy=%b done=%b, required busy=1 done=0", name, k, busy_s[d], done_s[d]);
                    end
                end
                if (k == lat) begin
                    n_checks++;
                    if (done_s[d] !== 1'b1 || busy_s[d] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s done_latency k=%0d: done=%b busy=%b, required done=1 busy=0", name, k, done_s[d], busy_s[d]);
                    end
                    n_checks++;
                    if (fm_s[d] !== e_fm || ec_s[d] !== e_ec || pass_s[d] !== e_pass) begin
                        n_fail++;
                        $display("FAIL %s results: fm=%h ec=%0d pass=%b, required fm=%h ec=%0d pass=%b", name, fm_s[d], ec_s[d], pass_s[d], e_fm, e_ec, e_pass);
                    end
                end
                if (k == lat + 1) begin
                    n_checks++;
                    if (done_s[d] !== 1'b0 || pass_s[d] !== e_pass || a_s[d] !== 1'b0 || b_s[d] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s after_done: done=%b pass=%b A=%b B=%b, required done=0 pass=%b A=0 B=0", name, done_s[d], pass_s[d], a_s[d], b_s[d], e_pass);
                    end
                end
            end
            glitch     = (glitchy && k < lat - 1 && (k % (s + 1)) != s) ? 7'($urandom) : 7'h00;
            start_s[d] = (k + 1 == repulse_k);
            rst        = (k == rst_k);
            @(posedge clk); #1;
        end
        glitch     = 7'h00;
        start_s[d] = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (a_s[d] !== 1'b0 || b_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 ||
                pass_s[d] !== 1'b0 || fm_s[d] !== 7'h00 || ec_s[d] !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: A=%b B=%b busy=%b done=%b pass=%b fm=%h ec=%0d, required all 0",
                         d, a_s[d], b_s[d], busy_s[d], done_s[d], pass_s[d], fm_s[d], ec_s[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        set_faults(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        run(0, 1, 1'b0, -1, -1, 7'h00, 5'd0, 1'b1, "clean");
        set_faults(7'h20, 7'h20, 7'h20, 7'h20, 7'h00);
        run(0, 1, 1'b0, -1, -1, 7'b0100000, 5'd4, 1'b0, "xor_as_xnor");
        set_faults(7'h00, 7'h00, 7'h00, 7'h00, 7'h01);
        run(0, 1, 1'b0, -1, -1, 7'b0000001, 5'd1, 1'b0, "and_stuck0");
        set_faults(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00);
        run(0, 1, 1'b0, -1, -1, 7'h7F, 5'd28, 1'b0, "all_inverted");
    endtask

    task automatic test_busy_restart();
        set_faults(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h00);
        run(0, 1, 1'b0, 4, -1, 7'h7F, 5'd28, 1'b0, "repulse_ignored");
        set_faults(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        run(0, 1, 1'b0, -1, -1, 7'h00, 5'd0, 1'b1, "restart_clears");
    endtask

    task automatic test_rst_mid_run();
        set_faults(7'h7F, 7'h00, 7'h00, 7'h00, 7'h00);
        run(0, 1, 1'b0, -1, 4, 7'h00, 5'd0, 1'b0, "rst_mid_run");
        set_faults(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        run(1, 3, 1'b0, -1, -1, 7'h00, 5'd0, 1'b1, "settle3");
    endtask

    task automatic test_back_to_back();
        int dones [$];
        set_faults(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        @(posedge clk); #1;
        start_s[0] = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done_s[0] === 1'b1) dones.push_back(k);
        end
        start_s[0] = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        n_checks++;
        if (dones.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: %0d done pulses, required 3", dones.size());
        end else begin
            n_checks++;
            if (dones[0] != 9 || dones[1] != 19 || dones[2] != 29) begin
                n_fail++;
                $display("FAIL b2b_timing: done at %0d,%0d,%0d, required 9,19,29", dones[0], dones[1], dones[2]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [6:0] m [4];
            logic [6:0] e_fm = 7'h00;
            int e_ec = 0;
            int d = it % 2;
            for (int v = 0; v < 4; v++) begin
                m[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
                e_fm |= m[v];
                e_ec += popc(m[v]);
            end
            set_faults(m[0], m[1], m[2], m[3], 7'h00);
            run(d, (d == 0) ? 1 : 3, 1'b1, -1, -1, e_fm, 5'((e_ec > 31) ? 31 : e_ec), (e_fm == 7'h00), "random");
        end
    endtask

    initial begin
        start_s = '0;
        glitch  = 7'h00;
        set_faults(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        test_reset();
        test_directed();
        test_busy_restart();
        test_rst_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
